// File: rtl/sargantana_tag_access_ctrl_if.sv
// Bundles the requester handshakes and the tag-way memory port of the tag access controller.
// The controller uses the slave modport; the requester/memory side uses the master modport.
interface sargantana_tag_access_ctrl_if #(
  parameter int unsigned NWAYS      = 4,
  parameter int unsigned TAG_WIDTH  = 20,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                       lkp_req_i;
  logic [ADDR_WIDTH-1:0]      lkp_idx_i;
  logic [TAG_WIDTH-1:0]       lkp_tag_i;
  logic                       lkp_ready_o;
  logic                       rsp_valid_o;
  logic                       rsp_hit_o;
  logic [NWAYS-1:0]           rsp_way_o;
  logic                       rfl_req_i;
  logic [ADDR_WIDTH-1:0]      rfl_idx_i;
  logic [TAG_WIDTH-1:0]       rfl_tag_i;
  logic                       rfl_done_o;
  logic [NWAYS-1:0]           rfl_way_o;
  logic                       flush_req_i;
  logic                       flush_done_o;
  logic                       busy_o;
  logic [NWAYS-1:0]           tag_req_o;
  logic [NWAYS-1:0]           tag_we_o;
  logic                       tag_vbit_o;
  logic                       tag_flush_o;
  logic [ADDR_WIDTH-1:0]      tag_addr_o;
  logic [TAG_WIDTH-1:0]       tag_wdata_o;
  logic [NWAYS*TAG_WIDTH-1:0] tag_rdata_i;
  logic [NWAYS-1:0]           tag_vbit_i;

  modport slave (
    input  lkp_req_i, lkp_idx_i, lkp_tag_i, rfl_req_i, rfl_idx_i, rfl_tag_i, flush_req_i,
           tag_rdata_i, tag_vbit_i,
    output lkp_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rfl_done_o, rfl_way_o, flush_done_o,
           busy_o, tag_req_o, tag_we_o, tag_vbit_o, tag_flush_o, tag_addr_o, tag_wdata_o
  );

  modport master (
    output lkp_req_i, lkp_idx_i, lkp_tag_i, rfl_req_i, rfl_idx_i, rfl_tag_i, flush_req_i,
           tag_rdata_i, tag_vbit_i,
    input  lkp_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rfl_done_o, rfl_way_o, flush_done_o,
           busy_o, tag_req_o, tag_we_o, tag_vbit_o, tag_flush_o, tag_addr_o, tag_wdata_o
  );
endinterface

// File: rtl/sargantana_tag_access_ctrl.sv
// Instruction-cache tag-way access controller: arbitrates flush > refill > lookup.
// Define ICACHE_FLUSH_SWEEP_EN to flush by sweeping every set instead of a one-cycle way flush.
module sargantana_tag_access_ctrl #(
  parameter int unsigned NWAYS      = 4,
  parameter int unsigned TAG_WIDTH  = 20,
  parameter int unsigned TAG_DEPTH  = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(TAG_DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  sargantana_tag_access_ctrl_if.slave bus
);
  localparam int unsigned WayW = $clog2(NWAYS);

  typedef enum logic [1:0] {StIdle, StRfRd, StRfWr, StFl} state_e;

  state_e                 state_q;
  logic [WayW-1:0]        rr_ptr_q;
  logic [NWAYS-1:0]       victim_q;
  logic                   rr_used_q;
  logic                   rsp_pending_q;
  logic [TAG_WIDTH-1:0]   lkp_tag_q;
  logic                   flush_done_q;
`ifdef ICACHE_FLUSH_SWEEP_EN
  logic [ADDR_WIDTH-1:0]  sweep_q;
`endif

  logic idle, acc_fl, acc_rf, acc_lk;

  assign idle   = (state_q == StIdle);
  // The requester still holds flush_req_i during the done cycle, so it must not re-arm a flush.
  assign acc_fl = idle & bus.flush_req_i & ~flush_done_q;
  assign acc_rf = idle & ~bus.flush_req_i & bus.rfl_req_i;
  assign acc_lk = idle & ~bus.flush_req_i & ~bus.rfl_req_i & bus.lkp_req_i;

  logic [WayW-1:0] vic_idx;
  logic            vic_free;

  // Downward scan leaves the lowest-index invalid way selected.
  always_comb begin
    vic_free = 1'b0;
    vic_idx  = rr_ptr_q;
    for (int w = int'(NWAYS) - 1; w >= 0; w--) begin
      if (!bus.tag_vbit_i[w]) begin
        vic_free = 1'b1;
        vic_idx  = WayW'(w);
      end
    end
  end

  logic [NWAYS-1:0] hit;

  always_comb begin
    hit = '0;
    for (int w = 0; w < int'(NWAYS); w++) begin
      hit[w] = bus.tag_vbit_i[w] & (bus.tag_rdata_i[w*TAG_WIDTH +: TAG_WIDTH] == lkp_tag_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      victim_q      <= '0;
      rr_used_q     <= 1'b0;
      rsp_pending_q <= 1'b0;
      lkp_tag_q     <= '0;
      flush_done_q  <= 1'b0;
`ifdef ICACHE_FLUSH_SWEEP_EN
      sweep_q       <= '0;
`endif
    end else begin
      rsp_pending_q <= acc_lk;
      flush_done_q  <= 1'b0;
      if (acc_lk) lkp_tag_q <= bus.lkp_tag_i;
      unique case (state_q)
        StIdle: begin
          if (acc_fl)      state_q <= StFl;
          else if (acc_rf) state_q <= StRfRd;
        end
        StRfRd: begin
          victim_q  <= NWAYS'(1) << vic_idx;
          rr_used_q <= ~vic_free;
          state_q   <= StRfWr;
        end
        StRfWr: begin
          if (rr_used_q) rr_ptr_q <= rr_ptr_q + 1'b1;
          state_q <= StIdle;
        end
        StFl: begin
`ifdef ICACHE_FLUSH_SWEEP_EN
          if (sweep_q == ADDR_WIDTH'(TAG_DEPTH - 1)) begin
            sweep_q      <= '0;
            state_q      <= StIdle;
            flush_done_q <= 1'b1;
          end else begin
            sweep_q <= sweep_q + 1'b1;
          end
`else
          state_q      <= StIdle;
          flush_done_q <= 1'b1;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reset forces every output low in the same cycle it is asserted.
  always_comb begin
    bus.lkp_ready_o  = 1'b0;
    bus.rsp_valid_o  = 1'b0;
    bus.rsp_hit_o    = 1'b0;
    bus.rsp_way_o    = '0;
    bus.rfl_done_o   = 1'b0;
    bus.rfl_way_o    = '0;
    bus.flush_done_o = 1'b0;
    bus.busy_o       = 1'b0;
    bus.tag_req_o    = '0;
    bus.tag_we_o     = '0;
    bus.tag_vbit_o   = 1'b0;
    bus.tag_flush_o  = 1'b0;
    bus.tag_addr_o   = '0;
    bus.tag_wdata_o  = '0;
    if (!rst_i) begin
      bus.lkp_ready_o  = idle & ~bus.flush_req_i & ~bus.rfl_req_i;
      bus.rsp_valid_o  = rsp_pending_q;
      bus.rsp_hit_o    = rsp_pending_q & (|hit);
      bus.rsp_way_o    = rsp_pending_q ? hit : '0;
      bus.busy_o       = ~idle;
      bus.flush_done_o = flush_done_q;
      if (acc_lk || acc_rf) begin
        bus.tag_req_o  = '1;
        bus.tag_addr_o = acc_lk ? bus.lkp_idx_i : bus.rfl_idx_i;
      end
      if (state_q == StRfWr) begin
        bus.tag_req_o   = victim_q;
        bus.tag_we_o    = victim_q;
        bus.tag_vbit_o  = 1'b1;
        bus.tag_addr_o  = bus.rfl_idx_i;
        bus.tag_wdata_o = bus.rfl_tag_i;
        bus.rfl_done_o  = 1'b1;
        bus.rfl_way_o   = victim_q;
      end
      if (state_q == StFl) begin
`ifdef ICACHE_FLUSH_SWEEP_EN
        bus.tag_req_o  = '1;
        bus.tag_we_o   = '1;
        bus.tag_addr_o = sweep_q;
`else
        bus.tag_flush_o = 1'b1;
`endif
      end
    end
  end

  // Requesters must hold refill/flush requests until the matching done pulse.
  assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q inside {StRfRd, StRfWr}) |-> bus.rfl_req_i);
  assert property (@(posedge clk_i) disable iff (rst_i)
    ((state_q == StFl) || flush_done_q) |-> bus.flush_req_i);

endmodule
